// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier: one conditional ripple-carry add and one right shift per clock.
// Signed operands are multiplied as magnitudes, and the product sign is restored in a single fix-up cycle.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int                 CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2 * WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [2*WIDTH:0]   p_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               neg_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH+1:0]   carry;
    logic [2*WIDTH:0]   p_run_d;

    // The most negative value maps to 2^(W-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    assign add_a    = p_q[2*WIDTH:WIDTH];
    assign add_b    = {1'b0, mcand_q};
    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_rca
            full_adder u_fa (
                .a_i   (add_a[i]),
                .b_i   (add_b[i]),
                .cin_i (carry[i]),
                .sum_o (add_sum[i]),
                .cout_o(carry[i+1])
            );
        end
    endgenerate

    // The adder carry-out becomes the new top bit after the shift.
    assign p_run_d = p_q[0] ? {carry[WIDTH+1], add_sum, p_q[WIDTH-1:1]}
                            : {1'b0, p_q[2*WIDTH:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        mcand_q <= magnitude(A, SIGNED_OP);
                        neg_q   <= SIGNED_OP & (A[WIDTH-1] ^ B[WIDTH-1]);
                        p_q     <= {{(WIDTH + 1){1'b0}}, magnitude(B, SIGNED_OP)};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    p_q     <= p_run_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST_CNT) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (neg_q) begin
                        p_q[2*WIDTH-1:0] <= ~p_q[2*WIDTH-1:0] + ONE_P;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    hi_q    <= p_q[2*WIDTH-1:WIDTH];
                    lo_q    <= p_q[WIDTH-1:0];
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed operand pairs with hand-computed products,
// checked by an independent monitor on each DONE pulse.

module tb_shift_add_multiplier;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         SIGNED_OP = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    wire          BUSY;
    wire          DONE;
    wire  [W-1:0] HI;
    wire  [W-1:0] LO;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SIGNED_OP(SIGNED_OP),
        .A        (A),
        .B        (B),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           acc;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           busy_cnt = 0;
    int           n_ops = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per DONE pulse.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST) begin
            busy_cnt = 0;
        end else begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    check("unexpected_done", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    check("hi", HI, e.hi);
                    check("lo", LO, e.lo);
                    check("latency", cyc - e.acc, 34);
                    check("busy_cycles", busy_cnt, 33);
                    check("busy_at_done", BUSY, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el, input int acc);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.acc = acc;
        sbq.push_back(e);
        n_ops++;
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        @(posedge CLK); #1;
        SIGNED_OP = s; A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        push_exp(eh, el, cyc);
        A = $urandom;
        B = $urandom;
        SIGNED_OP = ~s;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!DONE) check({nm, "_timeout"}, DONE, 1);
        #1;
    endtask

    task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eh, input logic [W-1:0] el);
        issue(s, a, b, eh, el);
        repeat (5) @(negedge CLK);
        check("hold_hi", HI, last_hi);
        check("hold_lo", LO, last_lo);
        wait_done("op");
        last_hi = eh;
        last_lo = el;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int d0;
        int a1;
        int a2;
        int n;
        repeat (3) @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        op(1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
        op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        op(1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A);
        op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        op(1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
        op(1'b0, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000);
        op(1'b1, 32'd0, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000);
        op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF);
        op(1'b0, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780);

        // Second START during RUN must be dropped.
        issue(1'b0, 32'd7, 32'd9, 32'h0, 32'h3F);
        repeat (9) @(posedge CLK);
        #1;
        START = 1'b1; A = 32'hAAAA; B = 32'h5555; SIGNED_OP = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done("ignored_start");
        last_hi = 32'h0; last_lo = 32'h3F;
        d0 = done_cnt;
        repeat (50) @(negedge CLK);
        check("single_done", done_cnt, d0);

        // Reset mid-run aborts the operation.
        issue(1'b0, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0);
        repeat (14) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        sbq.delete();
        n_ops--;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        d0 = done_cnt;
        repeat (50) @(negedge CLK);
        check("no_done_after_abort", done_cnt, d0);
        last_hi = '0; last_lo = '0;
        op(1'b1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

        // START held high: back-to-back operations with one idle cycle between.
        @(posedge CLK); #1;
        SIGNED_OP = 1'b0; A = 32'd3; B = 32'd5; START = 1'b1;
        @(posedge CLK); #1;
        a1 = cyc;
        push_exp(32'h0, 32'hF, a1);
        n = 0;
        while (!DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!DONE) check("b2b_timeout", DONE, 1);
        @(posedge CLK); #1;
        a2 = cyc;
        START = 1'b0;
        push_exp(32'h0, 32'hF, a2);
        check("b2b_gap", a2 - a1, 35);
        wait_done("b2b");

        repeat (5) @(negedge CLK);
        check("queue_empty", sbq.size(), 0);
        check("done_total", done_cnt, n_ops);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
